// File: rtl/mem_unit.sv
// mem_unit: unified RAM with byte-lane stores, load extension and a FIFO-backed console port.
package mem_pkg;
  typedef enum logic [3:0] {
    MEM_NOP, MEM_LB, MEM_LH, MEM_LW, MEM_LBU, MEM_LHU, MEM_SB, MEM_SH, MEM_SW
  } mem_inst_type_t;
endpackage

module mem_unit
  import mem_pkg::*;
#(
  parameter int          MEM_WORDS    = 16384,
  parameter logic [31:0] BASE_ADDR    = 32'h8000_0000,
  parameter logic [31:0] CONSOLE_ADDR = 32'h4000_0000,
  parameter int          FIFO_DEPTH   = 8,
  parameter string       INIT_FILE    = ""
) (
  input  logic           clk,
  input  logic           rst,
  input  mem_inst_type_t instType_i,
  input  logic [31:0]    dataAddress_i,
  input  logic [31:0]    writeData_i,
  output logic [31:0]    readData_o,
  output logic           err_o,
  output logic           cons_valid_o,
  output logic [7:0]     cons_data_o,
  input  logic           cons_ready_i
);
  localparam int AW = $clog2(MEM_WORDS);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [31:0] RAM_BYTES = 32'(4 * MEM_WORDS);
  logic [31:0] ram [MEM_WORDS];
  logic [7:0] fifo [FIFO_DEPTH];
  logic [PW-1:0] rdPtr, wrPtr;
  logic [PW:0] count;
  logic overflow;
  logic [31:0] offset, word, wdata, loadVal, status;
  logic [15:0] half;
  logic [7:0] lane;
  logic [3:0] byteEn;
  logic [AW-1:0] idx;
  logic isLoad, isStore, ramHit, consData, consStat, miss, push, pop, full, accept;

  always_comb begin
    isLoad   = instType_i inside {MEM_LB, MEM_LH, MEM_LW, MEM_LBU, MEM_LHU};
    isStore  = instType_i inside {MEM_SB, MEM_SH, MEM_SW};
    offset   = dataAddress_i - BASE_ADDR;
    ramHit   = offset < RAM_BYTES;
    idx      = offset[AW+1:2];
    consData = dataAddress_i == CONSOLE_ADDR;
    consStat = dataAddress_i == CONSOLE_ADDR + 32'd4;
    miss     = (isLoad | isStore) & ~(ramHit | consData | consStat);
    word     = ram[idx];
    lane     = 8'(word >> {dataAddress_i[1:0], 3'b000});
    half     = dataAddress_i[1] ? word[31:16] : word[15:0];
    loadVal  = instType_i == MEM_LB  ? {{24{lane[7]}}, lane} :
               instType_i == MEM_LBU ? {24'b0, lane} :
               instType_i == MEM_LH  ? {{16{half[15]}}, half} :
               instType_i == MEM_LHU ? {16'b0, half} : word;
    byteEn   = instType_i == MEM_SW ? 4'hF :
               instType_i == MEM_SH ? (dataAddress_i[1] ? 4'hC : 4'h3) :
               instType_i == MEM_SB ? 4'b0001 << dataAddress_i[1:0] : 4'h0;
    wdata    = instType_i == MEM_SB ? {4{writeData_i[7:0]}} :
               instType_i == MEM_SH ? {2{writeData_i[15:0]}} : writeData_i;
    full     = count == (PW+1)'(FIFO_DEPTH);
    pop      = cons_valid_o & cons_ready_i;
    push     = isStore & consData;
    accept   = push & (~full | pop);
    status   = {22'b0, overflow, full, 8'(count)};
  end

  assign cons_valid_o = count != '0;
  assign cons_data_o  = cons_valid_o ? fifo[rdPtr] : 8'h0;

  always_ff @(posedge clk)
    if (!rst && ramHit)
      for (int b = 0; b < 4; b++)
        if (byteEn[b]) ram[idx][8*b +: 8] <= wdata[8*b +: 8];

  always_ff @(posedge clk) begin
    if (rst) begin
      readData_o <= '0;
      err_o      <= 1'b0;
      rdPtr      <= '0;
      wrPtr      <= '0;
      count      <= '0;
      overflow   <= 1'b0;
    end else begin
      if (isLoad) readData_o <= ramHit ? loadVal : consStat ? status : 32'h0;
      err_o <= miss;
      if (accept) begin
        fifo[wrPtr] <= writeData_i[7:0];
        wrPtr       <= wrPtr + 1'b1;
      end
      if (pop) rdPtr <= rdPtr + 1'b1;
      count <= count + (PW+1)'(accept) - (PW+1)'(pop);
      if (push & ~accept) overflow <= 1'b1;
      else if (isStore & consStat) overflow <= 1'b0;
    end
  end
endmodule

// File: tb/tb_mem_unit.sv
// tb_mem_unit: directed test-plan sequences plus random traffic against a byte-addressed reference model.
module tb_mem_unit;
  import mem_pkg::*;
  logic clk = 0, rst = 1, cons_ready_i = 0;
  mem_inst_type_t instType_i = MEM_NOP;
  logic [31:0] dataAddress_i = 0, writeData_i = 0, readData_o;
  logic err_o, cons_valid_o;
  logic [7:0] cons_data_o;
  int nChecks = 0, nFails = 0;
  logic [7:0] mb [logic [31:0]];
  logic [7:0] q [$];
  logic ovf = 0;
  logic [31:0] expRd = 0;
  logic expErr = 0;

  mem_unit dut (
    .clk(clk), .rst(rst), .instType_i(instType_i), .dataAddress_i(dataAddress_i),
    .writeData_i(writeData_i), .readData_o(readData_o), .err_o(err_o),
    .cons_valid_o(cons_valid_o), .cons_data_o(cons_data_o), .cons_ready_i(cons_ready_i)
  );

  always #5 clk = ~clk;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    nChecks++;
    if (got !== exp) begin
      nFails++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] rb(logic [31:0] a);
    return mb.exists(a) ? mb[a] : 8'h00;
  endfunction

  task automatic step(mem_inst_type_t t, logic [31:0] a, logic [31:0] d, logic rdy, logic r);
    logic [31:0] wa, ha, w, stat;
    logic [15:0] h;
    logic [7:0] b;
    bit ramHit, cd, cs, ld, st, popM;
    instType_i = t; dataAddress_i = a; writeData_i = d; cons_ready_i = rdy; rst = r;
    @(posedge clk);
    #1;
    wa = {a[31:2], 2'b00};
    ha = {a[31:1], 1'b0};
    b = rb(a);
    h = {rb(ha + 1), rb(ha)};
    w = {rb(wa + 3), rb(wa + 2), rb(wa + 1), rb(wa)};
    ramHit = a >= 32'h8000_0000 && a < 32'h8001_0000;
    cd = a == 32'h4000_0000;
    cs = a == 32'h4000_0004;
    ld = t inside {MEM_LB, MEM_LH, MEM_LW, MEM_LBU, MEM_LHU};
    st = t inside {MEM_SB, MEM_SH, MEM_SW};
    popM = q.size() > 0 && rdy;
    stat = {22'b0, ovf, q.size() == 8, 8'(q.size())};
    if (r) begin
      expRd = 0; expErr = 0; ovf = 0; q.delete();
    end else begin
      expErr = (ld || st) && !(ramHit || cd || cs);
      if (ld)
        expRd = !ramHit ? (cs ? stat : 32'h0) :
                t == MEM_LB  ? 32'(signed'(b)) :
                t == MEM_LBU ? {24'h0, b} :
                t == MEM_LH  ? 32'(signed'(h)) :
                t == MEM_LHU ? {16'h0, h} : w;
      if (st && ramHit) begin
        if (t == MEM_SB) mb[a] = d[7:0];
        if (t == MEM_SH) begin mb[ha] = d[7:0]; mb[ha + 1] = d[15:8]; end
        if (t == MEM_SW) for (int i = 0; i < 4; i++) mb[wa + i] = d[8*i +: 8];
      end
      if (popM) void'(q.pop_front());
      if (st && cd) begin
        if (q.size() < 8) q.push_back(d[7:0]);
        else ovf = 1;
      end
      if (st && cs) ovf = 0;
    end
    chk("readData", readData_o, expRd);
    chk("err", 32'(err_o), 32'(expErr));
    chk("valid", 32'(cons_valid_o), 32'(q.size() != 0));
    chk("consData", 32'(cons_data_o), q.size() != 0 ? 32'(q[0]) : 32'h0);
  endtask

  initial begin
    logic [31:0] a, d;
    int k;
    step(MEM_NOP, 0, 0, 0, 1);
    step(MEM_LW, 32'h8000_0000, 0, 1, 1);
    chk("resetRd", readData_o, 32'h0);
    for (int i = 0; i < 64; i++) step(MEM_SW, 32'h8000_0000 + 4*i, $urandom, 0, 0);
    step(MEM_SW, 32'h8000_FFFC, 32'hCAFE_F00D, 0, 0);
    // fetch and hold
    step(MEM_SW, 32'h8000_0000, 32'h0000_0013, 0, 0);
    step(MEM_LW, 32'h8000_0000, 0, 0, 0);
    step(MEM_LW, 32'h8000_0000, 0, 0, 0);
    step(MEM_NOP, 32'h8000_0000, 0, 0, 0);
    chk("fetchHold", readData_o, 32'h0000_0013);
    // byte lanes
    step(MEM_SW, 32'h8000_0010, 32'h1122_3344, 0, 0);
    step(MEM_SB, 32'h8000_0012, 32'h0000_00FF, 0, 0);
    step(MEM_LW, 32'h8000_0010, 0, 0, 0);  chk("lanesLW", readData_o, 32'h11FF_3344);
    step(MEM_LB, 32'h8000_0012, 0, 0, 0);  chk("lanesLB", readData_o, 32'hFFFF_FFFF);
    step(MEM_LBU, 32'h8000_0012, 0, 0, 0); chk("lanesLBU", readData_o, 32'h0000_00FF);
    step(MEM_LH, 32'h8000_0012, 0, 0, 0);  chk("lanesLH", readData_o, 32'h0000_11FF);
    step(MEM_LHU, 32'h8000_0010, 0, 0, 0); chk("lanesLHU", readData_o, 32'h0000_3344);
    // sign extension
    step(MEM_SH, 32'h8000_0020, 32'h0000_8001, 0, 0);
    step(MEM_LH, 32'h8000_0020, 0, 0, 0);  chk("sextLH", readData_o, 32'hFFFF_8001);
    step(MEM_LHU, 32'h8000_0020, 0, 0, 0); chk("sextLHU", readData_o, 32'h0000_8001);
    // miss and RAM boundaries
    step(MEM_LW, 32'h0000_1000, 0, 0, 0);  chk("missRd", readData_o, 0); chk("missErr", 32'(err_o), 1);
    step(MEM_NOP, 0, 0, 0, 0);             chk("errPulse", 32'(err_o), 0);
    step(MEM_SW, 32'h0000_1000, 32'hDEAD_BEEF, 0, 0);
    step(MEM_LW, 32'h8000_FFFC, 0, 0, 0);  chk("lastWord", readData_o, 32'hCAFE_F00D);
    step(MEM_LW, 32'h8001_0000, 0, 0, 0);  chk("pastEnd", 32'(err_o), 1);
    step(MEM_LW, 32'h7FFF_FFFC, 0, 0, 0);  chk("belowBase", 32'(err_o), 1);
    // console backpressure and overflow
    for (int i = 0; i < 9; i++) step(MEM_SB, 32'h4000_0000, 32'h41 + i, 0, 0);
    step(MEM_LW, 32'h4000_0004, 0, 0, 0);  chk("statusOvf", readData_o, 32'h0000_0308);
    for (int i = 0; i < 8; i++) begin
      chk("drainHead", 32'(cons_data_o), 32'h41 + i);
      step(MEM_NOP, 0, 0, 1, 0);
    end
    chk("drainEmpty", 32'(cons_valid_o), 0);
    step(MEM_SW, 32'h4000_0004, 0, 1, 0);
    step(MEM_LW, 32'h4000_0004, 0, 1, 0);  chk("ovfClear", readData_o, 32'h0);
    // full push with simultaneous pop, then reset mid-stream
    for (int i = 0; i < 8; i++) step(MEM_SB, 32'h4000_0000, 32'h61 + i, 0, 0);
    step(MEM_SB, 32'h4000_0000, 32'h7A, 1, 0);
    step(MEM_LW, 32'h4000_0004, 0, 0, 0);  chk("fullPushPop", readData_o, 32'h0000_0108);
    step(MEM_LW, 32'h4000_0000, 0, 0, 0);  chk("consLoad", readData_o, 32'h0);
    step(MEM_LW, 32'h4000_0004, 0, 0, 0);
    step(MEM_SW, 32'h8000_0000, 32'h5555_AAAA, 0, 1);
    chk("rstValid", 32'(cons_valid_o), 0); chk("rstRd", readData_o, 0);
    step(MEM_LW, 32'h8000_0000, 0, 0, 0);  chk("rstDropStore", readData_o, 32'h0000_0013);
    // random traffic
    for (int n = 0; n < 1500; n++) begin
      k = $urandom_range(0, 9);
      a = k < 5 ? 32'h8000_0000 + $urandom_range(0, 255) :
          k < 7 ? 32'h4000_0000 :
          k < 8 ? 32'h4000_0004 :
          k < 9 ? 32'h8000_FFFC + $urandom_range(0, 3) : $urandom;
      if (a >= 32'h8000_0100 && a < 32'h8000_FFFC) a = 32'h0000_2000;
      d = $urandom;
      step(mem_inst_type_t'(4'($urandom_range(0, 15))), a, d,
           1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 99) == 0));
    end
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end
endmodule
